traffic_ctrl_multi: RTL and testbench

- Parametrised N-approach traffic light controller. It is the successor to the single-approach fixed RED/GREEN/YELLOW sequencer.
- Serves NUM_DIR approaches round-robin and skips approaches with no demand.
- Green length adapts to demand between GREEN_MIN and GREEN_MAX. An all-red clearance phase separates every green.
- A flashing-yellow maintenance mode is entered and left safely.
- Sits between the vehicle-detector front end and the lamp drivers. It is the DUT for the existing UVM traffic environment.

---
 rtl/traffic_ctrl_multi.sv | 108 ++++++++++
 tb/tb_traffic_ctrl_multi.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl_multi.sv
// traffic_ctrl_multi: round-robin N-approach traffic light controller with adaptive green, all-red clearance and flashing-yellow mode
module traffic_ctrl_multi #(
  parameter int NUM_DIR     = 4,
  parameter int ALL_RED_CYC = 2,
  parameter int GREEN_MIN   = 10,
  parameter int GREEN_MAX   = 15,
  parameter int YELLOW_CYC  = 5,
  parameter int FLASH_HALF  = 4,
  parameter int CNT_W       = 8,
  localparam int DW         = $clog2(NUM_DIR)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_DIR-1:0] req,
  input  logic               flash_en,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic [DW-1:0]      active_dir,
  output logic [1:0]         phase
);
  typedef enum logic [1:0] {ALL_RED, GREEN, YELLOW, FLASH} phase_t;
  localparam logic [CNT_W-1:0] AR_END = CNT_W'(ALL_RED_CYC - 1);
  localparam logic [CNT_W-1:0] GN_END = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GX_END = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_END  = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] F_END  = CNT_W'(FLASH_HALF - 1);
  phase_t st, nst;
  logic [CNT_W-1:0] cnt, ncnt;
  logic [DW-1:0] ndir, rr_dir, idx;
  logic flash_on, nflash_on, gap_or_max;
  logic [NUM_DIR-1:0] cur, noh, other_req;
  assign cur = NUM_DIR'(1) << active_dir;
  assign noh = NUM_DIR'(1) << ndir;
  assign other_req = req & ~cur;
  assign gap_or_max = cnt >= GN_END && |other_req && (!req[active_dir] || cnt == GX_END);
  assign phase = st;
  // round-robin pick starting after the current approach; the current one is searched last
  always_comb begin
    rr_dir = active_dir;
    idx = '0;
    for (int i = NUM_DIR; i >= 1; i--) begin
      idx = DW'((int'(active_dir) + i) % NUM_DIR);
      if (req[idx]) rr_dir = idx;
    end
  end
  // phase sequencing: clearance, green with gap/max-out, fixed yellow, flash override
  always_comb begin
    nst = st;
    ncnt = cnt + CNT_W'(1);
    ndir = active_dir;
    nflash_on = flash_on;
    case (st)
      ALL_RED:
        if (flash_en) begin
          nst = FLASH;
          ncnt = '0;
          nflash_on = 1'b1;
        end else if (cnt == AR_END) begin
          ncnt = cnt;
          if (|req) begin
            nst = GREEN;
            ncnt = '0;
            ndir = rr_dir;
          end
        end
      GREEN:
        if (flash_en || gap_or_max) begin
          nst = YELLOW;
          ncnt = '0;
        end else if (cnt == GX_END) ncnt = cnt;
      YELLOW:
        if (cnt == Y_END) begin
          nst = flash_en ? FLASH : ALL_RED;
          ncnt = '0;
          nflash_on = 1'b1;
        end
      default:
        if (!flash_en) begin
          nst = ALL_RED;
          ncnt = '0;
        end else if (cnt == F_END) begin
          ncnt = '0;
          nflash_on = !flash_on;
        end
    endcase
  end
  // state and lamp registers; lamps are decoded from the next state so they change with the phase
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st <= ALL_RED;
      cnt <= '0;
      active_dir <= DW'(NUM_DIR - 1);
      flash_on <= 1'b0;
      red <= '1;
      yellow <= '0;
      green <= '0;
    end else begin
      st <= nst;
      cnt <= ncnt;
      active_dir <= ndir;
      flash_on <= nflash_on;
      red <= nst == FLASH ? '0 : nst == ALL_RED ? '1 : ~noh;
      green <= nst == GREEN ? noh : '0;
      yellow <= nst == YELLOW ? noh : (nst == FLASH && nflash_on) ? '1 : '0;
    end
  end
endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// tb_traffic_ctrl_multi: directed scenarios plus random demand against a cycle-level reference model
module tb_traffic_ctrl_multi;
  localparam int N = 4, AR = 2, GMIN = 10, GMAX = 15, YC = 5, FH = 4;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] req = '0;
  logic flash_en = 1'b0;
  logic [N-1:0] red, yellow, green;
  logic [1:0] active_dir, phase;
  int total = 0;
  int passed = 0;
  int m_ph, m_t, m_dir;

  traffic_ctrl_multi #(
    .NUM_DIR(N), .ALL_RED_CYC(AR), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW_CYC(YC), .FLASH_HALF(FH), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .flash_en(flash_en),
    .red(red), .yellow(yellow), .green(green), .active_dir(active_dir), .phase(phase)
  );

  // free-running clock, period 10
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int rr_next(input int d, input logic [N-1:0] r);
    for (int i = 1; i <= N; i++) if (r[(d + i) % N]) return (d + i) % N;
    return d;
  endfunction

  task automatic model_reset();
    m_ph = 0;
    m_t = 0;
    m_dir = N - 1;
  endtask

  // one clock edge of the reference: m_t is the number of cycles already spent in the phase
  task automatic model_step();
    bit other;
    other = (req & ~(4'(1) << m_dir)) != 0;
    case (m_ph)
      0: if (flash_en) begin m_ph = 3; m_t = 0; end
         else if (m_t >= AR - 1 && req != 0) begin m_ph = 1; m_dir = rr_next(m_dir, req); m_t = 0; end
         else m_t++;
      1: if (flash_en || (m_t >= GMIN - 1 && other && (!req[m_dir] || m_t >= GMAX - 1))) begin m_ph = 2; m_t = 0; end
         else m_t++;
      2: if (m_t == YC - 1) begin m_ph = flash_en ? 3 : 0; m_t = 0; end
         else m_t++;
      default: if (!flash_en) begin m_ph = 0; m_t = 0; end
         else m_t++;
    endcase
  endtask

  task automatic check_all();
    logic [N-1:0] oh, er, ey, eg;
    int viol;
    oh = 4'(1) << m_dir;
    er = m_ph == 3 ? 4'h0 : m_ph == 0 ? 4'hF : ~oh;
    eg = m_ph == 1 ? oh : 4'h0;
    ey = m_ph == 2 ? oh : (m_ph == 3 && (m_t / FH) % 2 == 0) ? 4'hF : 4'h0;
    check("phase", int'(phase), m_ph);
    check("active_dir", int'(active_dir), m_dir);
    check("red", int'(red), int'(er));
    check("yellow", int'(yellow), int'(ey));
    check("green", int'(green), int'(eg));
    viol = 0;
    for (int i = 0; i < N; i++) if (int'(red[i]) + int'(yellow[i]) + int'(green[i]) > 1) viol++;
    if (phase != 2'd3 && $countones(~red) > 1) viol++;
    if ((phase == 2'd0 || phase == 2'd3) && green != 0) viol++;
    check("exclusive", viol, 0);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      if (reset) model_step();
      #1 check_all();
    end
  endtask

  task automatic wait_green(input int d, input int budget);
    int i = 0;
    while (green[d] !== 1'b1 && i < budget) begin
      cyc(1);
      i++;
    end
    check($sformatf("wait_green%0d", d), int'(green[d]), 1);
  endtask

  task automatic wait_phase(input int p, input int budget);
    int i = 0;
    while (int'(phase) != p && i < budget) begin
      cyc(1);
      i++;
    end
    check($sformatf("wait_phase%0d", p), int'(phase), p);
  endtask

  // assert reset between edges and confirm the lamps drop to all-red without a clock edge
  task automatic reset_mid();
    cyc(1);
    #2 reset = 1'b0;
    #1 model_reset();
    check("rst_red", int'(red), 15);
    check("rst_green", int'(green), 0);
    check("rst_yellow", int'(yellow), 0);
    check_all();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #12;
    check("por_red", int'(red), 15);
    check("por_dir", int'(active_dir), 3);
    check("por_phase", int'(phase), 0);
    check_all();
    @(negedge clock);
    req = 4'b0001;
    reset = 1'b1;
    cyc(1);
    check("s1_allred2", int'(red), 15);
    cyc(1);
    check("s1_green_start", int'(green), 1);
    cyc(53);
    check("s1_green_rest", int'(green), 1);
    check("s1_dir", int'(active_dir), 0);
    req = 4'b0101;
    wait_green(2, 40);
    wait_green(0, 40);
    cyc(30);
    req = 4'b0011;
    wait_green(0, 80);
    cyc(2);
    req = 4'b0010;
    wait_green(1, 40);
    req = 4'b0001;
    wait_green(0, 80);
    req = 4'b1000;
    wait_green(3, 60);
    check("s4_dir", int'(active_dir), 3);
    req = 4'b0001;
    wait_phase(0, 40);
    req = 4'b0000;
    cyc(20);
    check("s4_hold", int'(phase), 0);
    req = 4'b0100;
    wait_green(2, 10);
    req = 4'b0101;
    cyc(3);
    flash_en = 1'b1;
    wait_phase(3, 20);
    check("s5_flash_on", int'(yellow), 15);
    cyc(20);
    flash_en = 1'b0;
    cyc(3);
    check("s5_resume", int'(green), 1);
    cyc(5);
    reset_mid();
    req = 4'b0001;
    cyc(2);
    check("s6_green", int'(green), 1);
    cyc(10);
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) flash_en = !flash_en;
      if ($urandom_range(0, 399) == 0) reset_mid();
      else cyc(1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
